// File: rtl/axi_lite_regbank.sv
// AXI-Lite register bank: NumRegs x 32-bit registers with per-register hardware load and read-only mask.
// Define AXI_LITE_REGBANK_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
package axi_lite_regbank_pkg;
    typedef struct packed { logic [31:0] addr; } ax_chan_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_chan_t;
    typedef struct packed { logic [1:0] resp; logic user; } b_chan_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; logic user; } r_chan_t;
    typedef struct packed {
        ax_chan_t aw; logic aw_valid;
        w_chan_t  w;  logic w_valid;
        logic     b_ready;
        ax_chan_t ar; logic ar_valid;
        logic     r_ready;
    } req_t;
    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b; logic b_valid;
        logic    ar_ready;
        r_chan_t r; logic r_valid;
    } resp_t;
endpackage

module axi_lite_regbank #(
    parameter int                 NumRegs   = 8,
    parameter int                 AddrWidth = 32,
    parameter logic [NumRegs-1:0] RoMask    = '0,
    parameter logic [31:0]        RstVal    = 32'h0,
    parameter type                req_t     = axi_lite_regbank_pkg::req_t,
    parameter type                resp_t    = axi_lite_regbank_pkg::resp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  req_t                      axi_req_i,
    output resp_t                     axi_resp_o,
    output logic [NumRegs-1:0][31:0]  reg_q_o,
    input  logic [NumRegs-1:0][31:0]  reg_d_i,
    input  logic [NumRegs-1:0]        reg_load_i
);
    localparam int IdxW = AddrWidth - 2;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
`ifdef AXI_LITE_REGBANK_DECERR_EN
    localparam logic [1:0] RespOor    = 2'b11;
`else
    localparam logic [1:0] RespOor    = 2'b00;
`endif

    logic [NumRegs-1:0][31:0] r_regs;
    logic                     r_aw_full, r_w_full, r_b_valid, r_r_valid;
    logic [IdxW-1:0]          r_aw_idx;
    logic [31:0]              r_w_data, r_r_data;
    logic [3:0]               r_w_strb;
    logic [1:0]               r_b_resp, r_r_resp;

    logic                     w_aw_ready, w_w_ready, w_ar_ready;
    logic                     w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_do_write;
    logic [IdxW-1:0]          w_wr_idx, w_ar_idx;
    logic [31:0]              w_wr_data, w_rd_data;
    logic [3:0]               w_wr_strb;
    logic [NumRegs-1:0]       w_wr_sel, w_wr_en;
    logic [1:0]               w_wr_resp, w_rd_resp;
    logic                     w_wr_in_range, w_ar_in_range;
    logic                     w_unused;

    assign w_unused = ^{axi_req_i.aw.addr[1:0], axi_req_i.ar.addr[1:0]};

    // Write path: AW and W buffers stay full until the B handshake, which blocks new requests.
    assign w_aw_ready = !r_aw_full && !r_b_valid;
    assign w_w_ready  = !r_w_full && !r_b_valid;
    assign w_aw_hs    = axi_req_i.aw_valid && w_aw_ready;
    assign w_w_hs     = axi_req_i.w_valid && w_w_ready;
    assign w_b_hs     = r_b_valid && axi_req_i.b_ready;
    assign w_do_write = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs) && !r_b_valid;

    assign w_wr_idx  = r_aw_full ? r_aw_idx : axi_req_i.aw.addr[AddrWidth-1:2];
    assign w_wr_data = r_w_full ? r_w_data : axi_req_i.w.data;
    assign w_wr_strb = r_w_full ? r_w_strb : axi_req_i.w.strb;
    assign w_wr_in_range = w_wr_idx < IdxW'(NumRegs);

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NumRegs; i++) begin
            w_wr_sel[i] = (w_wr_idx == IdxW'(i));
        end
        w_wr_en = w_wr_sel & ~RoMask & {NumRegs{w_do_write}};
        if (!w_wr_in_range) begin
            w_wr_resp = RespOor;
        end else if (|(w_wr_sel & RoMask)) begin
            w_wr_resp = RespSlvErr;
        end else begin
            w_wr_resp = RespOkay;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_idx  <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_b_valid <= 1'b0;
            r_b_resp  <= '0;
        end else begin
            if (w_b_hs) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_idx  <= axi_req_i.aw.addr[AddrWidth-1:2];
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_w_data <= axi_req_i.w.data;
                    r_w_strb <= axi_req_i.w.strb;
                end
            end
            if (w_do_write) begin
                r_b_valid <= 1'b1;
                r_b_resp  <= w_wr_resp;
            end else if (w_b_hs) begin
                r_b_valid <= 1'b0;
            end
        end
    end

    // An AXI write wins over a hardware load of the same register; loads elsewhere still land.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_regs <= {NumRegs{RstVal}};
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                if (w_wr_en[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_wr_strb[b]) begin
                            r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                        end
                    end
                end else if (reg_load_i[i]) begin
                    r_regs[i] <= reg_d_i[i];
                end
            end
        end
    end

    // Read path: data captured from pre-edge register contents at the AR handshake.
    assign w_ar_ready    = !r_r_valid;
    assign w_ar_hs       = axi_req_i.ar_valid && w_ar_ready;
    assign w_r_hs        = r_r_valid && axi_req_i.r_ready;
    assign w_ar_idx      = axi_req_i.ar.addr[AddrWidth-1:2];
    assign w_ar_in_range = w_ar_idx < IdxW'(NumRegs);
    assign w_rd_resp     = w_ar_in_range ? RespOkay : RespOor;

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (w_ar_idx == IdxW'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= '0;
        end else if (w_ar_hs) begin
            r_r_valid <= 1'b1;
            r_r_data  <= w_rd_data;
            r_r_resp  <= w_rd_resp;
        end else if (w_r_hs) begin
            r_r_valid <= 1'b0;
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = w_aw_ready;
        axi_resp_o.w_ready  = w_w_ready;
        axi_resp_o.b_valid  = r_b_valid;
        axi_resp_o.b.resp   = r_b_resp;
        axi_resp_o.ar_ready = w_ar_ready;
        axi_resp_o.r_valid  = r_r_valid;
        axi_resp_o.r.data   = r_r_data;
        axi_resp_o.r.resp   = r_r_resp;
    end

    assign reg_q_o = r_regs;
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: vector table of write/readback pairs plus hand sequences.
module tb_axi_lite_regbank;
    import axi_lite_regbank_pkg::*;

`ifdef AXI_LITE_REGBANK_DECERR_EN
    localparam logic [1:0] OOR = 2'b11;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    req_t                req;
    resp_t               resp;
    logic [7:0][31:0]    reg_q, reg_d;
    logic [7:0]          reg_load;
    int                  n_checks = 0;
    int                  n_fail = 0;

    always #5 clk = ~clk;

    axi_lite_regbank #(
        .NumRegs(8), .AddrWidth(32), .RoMask(8'b0000_1000), .RstVal(32'h0),
        .req_t(req_t), .resp_t(resp_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_resp_o(resp),
        .reg_q_o(reg_q), .reg_d_i(reg_d), .reg_load_i(reg_load)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;
    localparam int NV = 7;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int   n;
        logic aw_go, w_go;
        n = 0;
        req.aw.addr = a; req.aw_valid = 1'b1;
        req.w.data = d; req.w.strb = s; req.w_valid = 1'b1;
        while ((req.aw_valid || req.w_valid) && n < 20) begin
            aw_go = req.aw_valid && resp.aw_ready;
            w_go  = req.w_valid && resp.w_ready;
            tick();
            if (aw_go) req.aw_valid = 1'b0;
            if (w_go) req.w_valid = 1'b0;
            n++;
        end
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        n = 0;
        while (!resp.b_valid && n < 20) begin
            tick();
            n++;
        end
        check("wr_b_valid_seen", {31'd0, resp.b_valid}, 32'd1);
        r = resp.b.resp;
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        req.ar.addr = a; req.ar_valid = 1'b1;
        while (!resp.ar_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        req.ar_valid = 1'b0;
        n = 0;
        while (!resp.r_valid && n < 20) begin
            tick();
            n++;
        end
        check("rd_r_valid_seen", {31'd0, resp.r_valid}, 32'd1);
        d = resp.r.data;
        r = resp.r.resp;
        req.r_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd;

        vecs[0] = '{32'h0000_0004, 32'h1234_5678, 4'hF, 2'b00, 32'h1234_5678, 2'b00};
        vecs[1] = '{32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b00};
        vecs[2] = '{32'h0000_0005, 32'hAABB_CCDD, 4'h8, 2'b00, 32'hAA34_5678, 2'b00};
        vecs[3] = '{32'h0000_0010, 32'hCAFE_F00D, 4'h0, 2'b00, 32'h0000_0000, 2'b00};
        vecs[4] = '{32'h0000_0400, 32'h1111_1111, 4'hF, OOR,   32'h0000_0000, OOR};
        vecs[5] = '{32'h0000_001C, 32'h0BAD_BEEF, 4'h5, 2'b00, 32'h00AD_00EF, 2'b00};
        vecs[6] = '{32'h0000_0020, 32'h0000_0005, 4'hF, OOR,   32'h0000_0000, OOR};

        req = '0; reg_d = '0; reg_load = '0;
        rst_n = 1'b0;
        #23;
        check("rst_b_valid", {31'd0, resp.b_valid}, 32'd0);
        check("rst_r_valid", {31'd0, resp.r_valid}, 32'd0);
        check("rst_r_data", resp.r.data, 32'd0);
        check("rst_reg1", reg_q[1], 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_readies", {29'd0, resp.aw_ready, resp.w_ready, resp.ar_ready}, 32'd7);

        // Same-cycle AW and W: B visible right after the write edge.
        req.aw.addr = 32'h4; req.aw_valid = 1'b1;
        req.w.data = 32'h1234_5678; req.w.strb = 4'hF; req.w_valid = 1'b1;
        check("s1_b_before", {31'd0, resp.b_valid}, 32'd0);
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        check("s1_b_valid", {31'd0, resp.b_valid}, 32'd1);
        check("s1_b_resp", {30'd0, resp.b.resp}, 32'd0);
        check("s1_reg1", reg_q[1], 32'h1234_5678);
        check("s1_aw_ready_blocked", {31'd0, resp.aw_ready}, 32'd0);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("s1_b_cleared", {31'd0, resp.b_valid}, 32'd0);
        check("s1_aw_ready_back", {31'd0, resp.aw_ready}, 32'd1);

        // W three cycles ahead of AW, single-byte strobe.
        req.w.data = 32'hAABB_CCDD; req.w.strb = 4'b0010; req.w_valid = 1'b1;
        tick();
        req.w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("s2_w_ready_low", {31'd0, resp.w_ready}, 32'd0);
            check("s2_no_b_yet", {31'd0, resp.b_valid}, 32'd0);
            if (i < 2) tick();
        end
        req.aw.addr = 32'h8; req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        check("s2_b_valid", {31'd0, resp.b_valid}, 32'd1);
        check("s2_reg2", reg_q[2], 32'h0000_CC00);
        tick();
        check("s2_b_held", {31'd0, resp.b_valid}, 32'd1);
        check("s2_w_ready_wait_b", {31'd0, resp.w_ready}, 32'd0);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("s2_w_ready_back", {31'd0, resp.w_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, br);
            check($sformatf("vec%0d_bresp", i), {30'd0, br}, {30'd0, vecs[i].bresp});
            axi_read(vecs[i].addr, rd, rr);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_rresp", i), {30'd0, rr}, {30'd0, vecs[i].rresp});
        end
        check("vec_reg3_ro", reg_q[3], 32'd0);

        // Hardware load, then write vs load collision with a same-edge read.
        reg_d[0] = 32'h55; reg_load[0] = 1'b1;
        tick();
        reg_load = '0;
        check("s3_load_reg0", reg_q[0], 32'h55);
        req.aw.addr = 32'h0; req.aw_valid = 1'b1;
        req.w.data = 32'h1; req.w.strb = 4'hF; req.w_valid = 1'b1;
        req.ar.addr = 32'h0; req.ar_valid = 1'b1;
        reg_d[0] = 32'h2; reg_load[0] = 1'b1;
        reg_d[2] = 32'h77; reg_load[2] = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0; reg_load = '0;
        check("s3_write_wins", reg_q[0], 32'h1);
        check("s3_other_load", reg_q[2], 32'h77);
        check("s3_r_valid", {31'd0, resp.r_valid}, 32'd1);
        check("s3_old_rdata", resp.r.data, 32'h55);
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        tick();
        req.b_ready = 1'b0; req.r_ready = 1'b0;
        check("s3_both_done", {30'd0, resp.b_valid, resp.r_valid}, 32'd0);

        // R held under backpressure, AW left in flight, then reset mid-wait.
        req.ar.addr = 32'h4; req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        req.aw.addr = 32'h14; req.aw_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("s4_r_valid_held", {31'd0, resp.r_valid}, 32'd1);
            check("s4_r_data_held", resp.r.data, 32'hAA34_5678);
            check("s4_ar_ready_low", {31'd0, resp.ar_ready}, 32'd0);
            tick();
            req.aw_valid = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("s4_rst_r_valid", {31'd0, resp.r_valid}, 32'd0);
        check("s4_rst_r_data", resp.r.data, 32'd0);
        check("s4_rst_reg1", reg_q[1], 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        check("s4_readies", {29'd0, resp.aw_ready, resp.w_ready, resp.ar_ready}, 32'd7);
        req.w.data = 32'h99; req.w.strb = 4'hF; req.w_valid = 1'b1;
        tick();
        req.w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("s4_no_stale_b", {31'd0, resp.b_valid}, 32'd0);
            tick();
        end
        check("s4_reg5_untouched", reg_q[5], 32'd0);
        req.aw.addr = 32'h18; req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        check("s4_b_after_aw", {31'd0, resp.b_valid}, 32'd1);
        check("s4_reg6", reg_q[6], 32'h99);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
